serial_in: RTL and testbench
============================

Name: serial_in

Overview:
- Serial-to-parallel receiver sitting directly downstream of the 16-bit serial_out shifter.
- Consumes the serial bit stream D, MSB first, framed by the same start strobe that loads the shifter.
- Reassembles each frame into a parallel word and presents it with a one-cycle valid pulse to the consuming logic.
- Provides busy and abort status for frame tracking.

Parameters:
- WIDTH, 16, frame length in bits; must match the upstream shifter width.
- CNT_W, 4, bit counter width; equals ceil(log2(WIDTH)).

Ports:
- clk  input  1  rising-edge clock, shared with the upstream shifter.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame-begin strobe, the same net that loads the upstream shifter; sampled synchronously here.
- D  input  1  serial data, MSB first.
- dout  output  WIDTH  last fully received word; holds its value between frames.
- valid  output  1  one-cycle pulse when dout has just been updated.
- busy  output  1  high while a frame is being received.
- abort  output  1  one-cycle pulse when a frame in progress is restarted by start.

Behaviour:
- Reset: asserting rst forces the following immediately, regardless of clk:
  - state IDLE
  - shreg 0
  - cnt 0
  - dout 0
  - valid 0, busy 0, abort 0
- rst wins over every other input. Reset mid-frame discards the partial frame, and dout returns to 0.
- All outputs are registered. busy = (state == SHIFT).
- States: IDLE and SHIFT.
- IDLE:
  - On an edge with start=1: shreg <= {0..., D}, cnt <= 1, state goes to SHIFT.
  - The D sampled on this edge is frame bit WIDTH-1 (MSB). The upstream shifter holds din[15] on D while start is high.
  - On an edge with start=0: no change.
- SHIFT, on each edge with start=0:
  - shreg <= {shreg[WIDTH-2:0], D}, cnt <= cnt+1.
  - If cnt == WIDTH-1 (last bit sampled on this edge):
    - dout <= {shreg[WIDTH-2:0], D}
    - valid <= 1
    - cnt <= 0
    - state goes to IDLE
- SHIFT, on an edge with start=1 (restart mid-frame):
  - abort <= 1; the partial frame is discarded and dout is unchanged.
  - shreg <= {0..., D}, cnt <= 1, state stays SHIFT. The new frame's MSB is taken on this edge.
- Latency:
  - Call the start edge edge 0. The LSB is sampled on edge WIDTH-1 (edge 15 at default).
  - dout and valid are visible after edge WIDTH-1; valid drops at edge WIDTH.
- valid and abort: each is high for exactly one cycle and defaults to 0 on every edge where it is not set.
- Back-to-back frames: if start=1 on the edge immediately after completion (state IDLE, valid high), the new frame begins normally. The valid pulse still completes and dout is not disturbed until the next completion.
- start held high for several edges: each edge restarts the frame. In SHIFT this pulses abort every edge, which mirrors the shifter being held loaded.
- D is don't-care in IDLE when start=0.
- dout only ever changes on a completed frame or on reset.

Decomposition:
- Shared package holds:
  - WIDTH = 16, CNT_W = 4
  - state encoding: IDLE = 1'b0, SHIFT = 1'b1
- The serial_out instance uses the same WIDTH.
- No sub-module is needed: counter, shift register and FSM are a single always block plus output registers.
- The bench instantiates serial_out -> serial_in back-to-back as the reference loopback.

Test Plan:
- Single frame: rst pulse, then start for one cycle with din=16'hA5C3 into serial_out, D chained -> dout = 16'hA5C3 and valid high for exactly one cycle, after edge 15 counted from the start edge; busy high during edges 0..15.
- Back-to-back frames: frames 16'hFFFF then 16'h0001, with the second start on the cycle valid is high -> dout = 16'hFFFF then 16'h0001, two valid pulses exactly 16 cycles apart, no abort.
- Mid-frame restart: start=1 at edge 7 of a 16'h1234 frame, new din=16'h8001 -> abort pulses once; dout = 16'h8001 after edge 22 counted from the first start edge; dout never shows 16'h1234 or any partial value.
- Reset mid-frame: assert rst asynchronously (between clock edges) at bit 9 -> all outputs and state clear immediately. A following frame 16'h5A5A completes correctly: dout = 16'h5A5A with one valid pulse.
- Idle noise: toggle D randomly for 40 cycles with start=0 -> busy, valid, abort stay 0 and dout holds its prior value.

Source files
------------

// File: rtl/serial_in_pkg.sv
// Shared definitions for the serial_out -> serial_in link: frame geometry and
// receiver state encoding.
package serial_in_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_BIT = cnt_t'(WIDTH - 1);

  // The first sampled bit of a frame lands in bit 0 of an otherwise clear register.
  function automatic word_t first_bit(input logic d);
    return {{(WIDTH-1){1'b0}}, d};
  endfunction

endpackage

// File: rtl/serial_in_if.sv
// Frame-level signals between the serial source and the serial_in receiver.
interface serial_in_if;
  import serial_in_pkg::*;

  logic  start;
  logic  D;
  word_t dout;
  logic  valid;
  logic  busy;
  logic  abort;

  modport master (
    output start, D,
    input  dout, valid, busy, abort
  );

  modport slave (
    input  start, D,
    output dout, valid, busy, abort
  );

endinterface

// File: rtl/serial_out.sv
// Upstream MSB-first shifter: start loads din and presents din[MSB] on D
// during the load cycle, so the receiver can sample the MSB on the start edge.
module serial_out
  import serial_in_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  word_t din,
  output logic  D
);

  word_t shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (start) begin
      shreg <= {din[WIDTH-2:0], 1'b0};
    end else begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign D = start ? din[WIDTH-1] : shreg[WIDTH-1];

endmodule

// File: rtl/serial_in.sv
// Serial-to-parallel receiver: collects WIDTH bits MSB first after each start
// strobe and publishes the word with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | waiting for start; dout holds the last completed word
// SHIFT | frame in progress; cnt bits already captured into shreg
module serial_in
  import serial_in_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  serial_in_if.slave  bus
);

  state_t state, state_nxt;
  word_t  shreg, shreg_nxt;
  cnt_t   cnt,   cnt_nxt;
  word_t  dout_q, dout_nxt;
  logic   valid_q, valid_nxt;
  logic   abort_q, abort_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      abort_q <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    dout_nxt  = dout_q;
    valid_nxt = 1'b0;
    abort_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          shreg_nxt = first_bit(bus.D);
          cnt_nxt   = cnt_t'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.start) begin
          // Restart: the partial word is dropped, dout keeps the last good frame.
          abort_nxt = 1'b1;
          shreg_nxt = first_bit(bus.D);
          cnt_nxt   = cnt_t'(1);
        end else begin
          shreg_nxt = {shreg[WIDTH-2:0], bus.D};
          cnt_nxt   = cnt + cnt_t'(1);
          if (cnt == LAST_BIT) begin
            dout_nxt  = {shreg[WIDTH-2:0], bus.D};
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.abort = abort_q;
  assign bus.busy  = (state == SHIFT);

endmodule

// File: tb/tb_serial_in.sv
// Loopback bench: serial_out drives serial_in; a frame-level model predicts
// completed words, abort pulses and busy, and a monitor checks them.
module tb_serial_in;
  import serial_in_pkg::*;

  typedef struct {
    int    e;
    word_t w;
  } ev_t;

  logic  clk;
  logic  rst;
  logic  start;
  word_t din;
  logic  so_d;
  logic  noise_en;
  logic  noise_d;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  ev_t   wq[$];
  int    aq[$];
  bit    exp_busy[int];
  word_t hold;

  // Frame-level model: a frame started on edge s completes on edge s+WIDTH-1
  // unless another start arrives before that.
  bit    m_active;
  int    m_start_e;
  word_t m_word;

  serial_in_if bus ();

  serial_out u_src (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .D     (so_d)
  );

  serial_in u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.start = start;
  assign bus.D     = noise_en ? noise_d : so_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Called at posedge+1: sets inputs for the next edge and predicts its outcome.
  task automatic do_edge(input logic st, input word_t w);
    int e;
    ev_t ev;
    e        = edge_n + 1;
    start    = st;
    din      = w;
    noise_d  = 1'($urandom_range(0, 1));
    if (st) begin
      if (m_active) aq.push_back(e);
      m_active  = 1'b1;
      m_start_e = e;
      m_word    = w;
    end else if (m_active && (e - m_start_e == WIDTH - 1)) begin
      ev.e = e;
      ev.w = m_word;
      wq.push_back(ev);
      m_active = 1'b0;
    end
    exp_busy[e] = m_active;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_edges(input int n);
    for (int i = 0; i < n; i++) do_edge(1'b0, word_t'($urandom));
  endtask

  task automatic send_frame(input word_t w);
    do_edge(1'b1, w);
    idle_edges(WIDTH - 1);
  endtask

  // Asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_dout",  bus.dout,  0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy",  bus.busy,  0);
    check("rst_abort", bus.abort, 0);
    exp_busy.delete(edge_n);
    m_active = 1'b0;
    hold     = '0;
    start    = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.valid) begin
          if (wq.size() == 0) begin
            check("valid_unexpected", 1, 0);
          end else begin
            ev = wq.pop_front();
            check("valid_edge", edge_n, ev.e);
            check("dout_word", bus.dout, ev.w);
            hold = ev.w;
          end
        end else if (wq.size() != 0 && wq[0].e <= edge_n) begin
          ev = wq.pop_front();
          check("valid_missing", 0, 1);
        end
        check("dout_hold", bus.dout, hold);

        if (bus.abort) begin
          if (aq.size() == 0) check("abort_unexpected", 1, 0);
          else check("abort_edge", edge_n, aq.pop_front());
        end else if (aq.size() != 0 && aq[0] <= edge_n) begin
          void'(aq.pop_front());
          check("abort_missing", 0, 1);
        end

        if (exp_busy.exists(edge_n)) begin
          check("busy", bus.busy, exp_busy[edge_n]);
          exp_busy.delete(edge_n);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    din      = '0;
    noise_en = 1'b0;
    noise_d  = 1'b0;
    hold     = '0;
    m_active = 1'b0;
    m_start_e = 0;
    m_word   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout",  bus.dout,  0);
    check("reset_valid", bus.valid, 0);
    check("reset_busy",  bus.busy,  0);
    check("reset_abort", bus.abort, 0);
    rst = 1'b0;
    idle_edges(3);

    // single frame
    send_frame(16'hA5C3);
    idle_edges(4);

    // back-to-back: second start on the edge right after completion
    send_frame(16'hFFFF);
    send_frame(16'h0001);
    idle_edges(4);

    // mid-frame restart on edge 7
    do_edge(1'b1, 16'h1234);
    idle_edges(6);
    send_frame(16'h8001);
    idle_edges(4);

    // reset after 9 bits of a frame
    do_edge(1'b1, 16'hC0DE);
    idle_edges(8);
    async_reset();
    idle_edges(2);
    send_frame(16'h5A5A);
    idle_edges(4);

    // idle noise on D
    noise_en = 1'b1;
    idle_edges(40);
    noise_en = 1'b0;
    idle_edges(2);

    // random frames, restarts and held start
    for (int i = 0; i < 600; i++) begin
      do_edge(1'($urandom_range(0, 11) == 0), word_t'($urandom));
    end
    idle_edges(WIDTH + 4);

    @(negedge clk);
    #1;
    check("wq_empty", wq.size(), 0);
    check("aq_empty", aq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
